// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller: opcodes, FSM states,
// datapath select encodings and opcode classes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcI      = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcLui    = 7'b0110111;

    typedef enum logic [3:0] {
        StRst    = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StExec   = 4'd3,
        StAddr   = 4'd4,
        StMem    = 4'd5,
        StWb     = 4'd6,
        StBranch = 4'd7,
        StJump   = 4'd8,
        StTrap   = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        SrcAPc    = 2'b00,
        SrcARs1   = 2'b01,
        SrcAZero  = 2'b10,
        SrcAOldPc = 2'b11
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SrcBRs2  = 2'b00,
        SrcBFour = 2'b01,
        SrcBImm  = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        M2rAluOut = 2'b00,
        M2rMdr    = 2'b01,
        M2rPc     = 2'b10
    } mem_to_reg_e;

    typedef enum logic [1:0] {
        PcSrcAlu    = 2'b00,
        PcSrcAluOut = 2'b01
    } pc_src_e;

    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluSub   = 2'b01,
        AluFunct = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        ClsR,
        ClsI,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJal,
        ClsLui,
        ClsIllegal
    } opc_class_e;

endpackage

// File: rtl/riscv_opcode_classifier.sv
// Combinational opcode to instruction-class mapping; JAL/LUI are only
// recognised when SUPPORT_JUMP is set.
module riscv_opcode_classifier
    import riscv_ctrl_pkg::*;
#(
    parameter bit SUPPORT_JUMP = 1'b1
) (
    input  logic [6:0] opcode,
    output opc_class_e opc_class
);

    always_comb begin
        opc_class = ClsIllegal;
        case (opcode)
            OpcR:      opc_class = ClsR;
            OpcI:      opc_class = ClsI;
            OpcLoad:   opc_class = ClsLoad;
            OpcStore:  opc_class = ClsStore;
            OpcBranch: opc_class = ClsBranch;
            OpcJal:    opc_class = SUPPORT_JUMP ? ClsJal : ClsIllegal;
            OpcLui:    opc_class = SUPPORT_JUMP ? ClsLui : ClsIllegal;
            default:   opc_class = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RISC-V control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// shared-datapath selects and counts retired instructions.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter bit          SUPPORT_JUMP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             instr_valid,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_dbg
);

    state_e           state_q, state_d;
    opc_class_e       cls_q, dec_cls;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    riscv_opcode_classifier #(
        .SUPPORT_JUMP(SUPPORT_JUMP)
    ) u_classifier (
        .opcode   (opcode),
        .opc_class(dec_cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRst;
            cls_q     <= ClsIllegal;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) cls_q <= dec_cls;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            StRst:   state_d = StFetch;
            StFetch: if (instr_valid) state_d = StDecode;
            StDecode: begin
                case (dec_cls)
                    ClsR, ClsI, ClsLui: state_d = StExec;
                    ClsLoad, ClsStore:  state_d = StAddr;
                    ClsBranch:          state_d = StBranch;
                    ClsJal:             state_d = StJump;
                    default:            state_d = StTrap;
                endcase
            end
            StExec: state_d = StWb;
            StAddr: state_d = StMem;
            StMem: begin
                if (mem_ready) begin
                    if (cls_q == ClsLoad) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                end
            end
            StWb, StBranch, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StRst;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_src        = PcSrcAlu;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src_a     = SrcAPc;
        alu_src_b     = SrcBRs2;
        alu_op        = AluAdd;
        mem_to_reg    = M2rAluOut;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcBFour;
                ir_write  = instr_valid;
                pc_write  = instr_valid;
            end
            // ALUOut captures the branch/jump target while the class is decoded
            StDecode: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
            end
            StExec: begin
                alu_op = AluFunct;
                case (cls_q)
                    ClsR: begin
                        alu_src_a = SrcARs1;
                        alu_src_b = SrcBRs2;
                    end
                    ClsLui: begin
                        alu_src_a = SrcAZero;
                        alu_src_b = SrcBImm;
                        alu_op    = AluAdd;
                    end
                    default: begin
                        alu_src_a = SrcARs1;
                        alu_src_b = SrcBImm;
                    end
                endcase
            end
            StAddr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
            end
            StMem: begin
                i_or_d    = 1'b1;
                mem_read  = (cls_q == ClsLoad);
                mem_write = (cls_q == ClsStore);
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == ClsLoad) ? M2rMdr : M2rAluOut;
            end
            StBranch: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluSub;
                pc_src    = PcSrcAluOut;
                pc_write  = zero;
            end
            StJump: begin
                pc_src     = PcSrcAluOut;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = M2rPc;
            end
            StTrap:  illegal_instr = 1'b1;
            default: ;
        endcase
    end

    assign instret   = instret_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: dut_a (CNT_W=32, jumps on) and
// dut_b (CNT_W=4, jumps off) share stimulus; expected per-cycle outputs are queued.
module tb_riscv_multicycle_ctrl;

    // Packed output order: state pc_write pc_src ir_write i_or_d mem_read mem_write
    //                      alu_src_a alu_src_b alu_op mem_to_reg reg_write illegal_instr
    localparam logic [20:0] V_RST  = 21'd0;
    localparam logic [20:0] V_F0   = {4'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0,
                                      2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] V_F1   = {4'd1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0,
                                      2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] V_DEC  = {4'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                      2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] V_EXR  = {4'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                      2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] V_EXI  = {4'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                      2'b01, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] V_EXL  = {4'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                      2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] V_ADDR = {4'd4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                      2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] V_MEML = {4'd5, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0,
                                      2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] V_MEMS = {4'd5, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1,
                                      2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] V_WB0  = {4'd6, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                      2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [20:0] V_WB1  = {4'd6, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                      2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0};
    localparam logic [20:0] V_BR1  = {4'd7, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0,
                                      2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] V_BR0  = {4'd7, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0,
                                      2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam logic [20:0] V_JMP  = {4'd8, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0,
                                      2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
    localparam logic [20:0] V_TRAP = {4'd9, 16'd0, 1'b1};

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct {
        logic [20:0] v;
        logic [31:0] cnt;
        bit          sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  opcode = '0;
    logic        instr_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;

    logic        a_pc_write, a_ir_write, a_i_or_d, a_mem_read, a_mem_write;
    logic        a_reg_write, a_illegal_instr;
    logic [1:0]  a_pc_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_mem_to_reg;
    logic [31:0] a_instret;
    logic [3:0]  a_state_dbg;

    logic        b_pc_write, b_ir_write, b_i_or_d, b_mem_read, b_mem_write;
    logic        b_reg_write, b_illegal_instr;
    logic [1:0]  b_pc_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_mem_to_reg;
    logic [3:0]  b_instret;
    logic [3:0]  b_state_dbg;

    logic [20:0] vec_a, vec_b;
    exp_t        sb[$];
    bit          cur_sel;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;
    int          errors = 0;
    int          checks = 0;
    int          cycle_no = 0;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl #(
        .CNT_W(32),
        .SUPPORT_JUMP(1'b1)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .mem_ready    (mem_ready),
        .zero         (zero),
        .pc_write     (a_pc_write),
        .pc_src       (a_pc_src),
        .ir_write     (a_ir_write),
        .i_or_d       (a_i_or_d),
        .mem_read     (a_mem_read),
        .mem_write    (a_mem_write),
        .alu_src_a    (a_alu_src_a),
        .alu_src_b    (a_alu_src_b),
        .alu_op       (a_alu_op),
        .mem_to_reg   (a_mem_to_reg),
        .reg_write    (a_reg_write),
        .illegal_instr(a_illegal_instr),
        .instret      (a_instret),
        .state_dbg    (a_state_dbg)
    );

    riscv_multicycle_ctrl #(
        .CNT_W(4),
        .SUPPORT_JUMP(1'b0)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .mem_ready    (mem_ready),
        .zero         (zero),
        .pc_write     (b_pc_write),
        .pc_src       (b_pc_src),
        .ir_write     (b_ir_write),
        .i_or_d       (b_i_or_d),
        .mem_read     (b_mem_read),
        .mem_write    (b_mem_write),
        .alu_src_a    (b_alu_src_a),
        .alu_src_b    (b_alu_src_b),
        .alu_op       (b_alu_op),
        .mem_to_reg   (b_mem_to_reg),
        .reg_write    (b_reg_write),
        .illegal_instr(b_illegal_instr),
        .instret      (b_instret),
        .state_dbg    (b_state_dbg)
    );

    assign vec_a = {a_state_dbg, a_pc_write, a_pc_src, a_ir_write, a_i_or_d, a_mem_read,
                    a_mem_write, a_alu_src_a, a_alu_src_b, a_alu_op, a_mem_to_reg,
                    a_reg_write, a_illegal_instr};
    assign vec_b = {b_state_dbg, b_pc_write, b_pc_src, b_ir_write, b_i_or_d, b_mem_read,
                    b_mem_write, b_alu_src_a, b_alu_src_b, b_alu_op, b_mem_to_reg,
                    b_reg_write, b_illegal_instr};

    // One clock cycle: drive inputs, queue the expectation, compare at the falling edge.
    task automatic cyc(input logic [20:0] v, input logic iv, input logic mr, input bit ret);
        exp_t        e;
        logic [20:0] obs;
        logic [31:0] obs_cnt;
        instr_valid = iv;
        mem_ready   = mr;
        e.v   = v;
        e.sel = cur_sel;
        e.cnt = cur_sel ? {28'd0, cnt_b} : cnt_a;
        sb.push_back(e);
        @(negedge clk);
        e       = sb.pop_front();
        obs     = e.sel ? vec_b : vec_a;
        obs_cnt = e.sel ? {28'd0, b_instret} : a_instret;
        checks++;
        if (obs !== e.v) begin
            errors++;
            $display("FAIL outputs dut_%s cycle %0d: got %h expected %h",
                     e.sel ? "b" : "a", cycle_no, obs, e.v);
        end
        checks++;
        if (obs_cnt !== e.cnt) begin
            errors++;
            $display("FAIL instret dut_%s cycle %0d: got %0d expected %0d",
                     e.sel ? "b" : "a", cycle_no, obs_cnt, e.cnt);
        end
        if (ret) begin
            if (cur_sel) cnt_b = cnt_b + 4'd1;
            else cnt_a = cnt_a + 32'd1;
        end
        cycle_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        opcode      = '0;
        zero        = 1'b0;
        cnt_a       = '0;
        cnt_b       = '0;
        cyc(V_RST, 1'b0, 1'b0, 1'b0);
        cyc(V_RST, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        cyc(V_RST, 1'b1, 1'b1, 1'b0);
    endtask

    // Full instruction from FETCH to retirement (jump-capable decode).
    task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input logic z);
        opcode = opc;
        zero   = z;
        repeat (fw) cyc(V_F0, 1'b0, 1'b0, 1'b0);
        cyc(V_F1, 1'b1, 1'b1, 1'b0);
        cyc(V_DEC, 1'b1, 1'b1, 1'b0);
        case (opc)
            OP_R:   begin cyc(V_EXR, 1'b1, 1'b1, 1'b0); cyc(V_WB0, 1'b1, 1'b1, 1'b1); end
            OP_I:   begin cyc(V_EXI, 1'b1, 1'b1, 1'b0); cyc(V_WB0, 1'b1, 1'b1, 1'b1); end
            OP_LUI: begin cyc(V_EXL, 1'b1, 1'b1, 1'b0); cyc(V_WB0, 1'b1, 1'b1, 1'b1); end
            OP_LOAD: begin
                cyc(V_ADDR, 1'b1, 1'b0, 1'b0);
                repeat (mw) cyc(V_MEML, 1'b1, 1'b0, 1'b0);
                cyc(V_MEML, 1'b1, 1'b1, 1'b0);
                cyc(V_WB1, 1'b1, 1'b1, 1'b1);
            end
            OP_STORE: begin
                cyc(V_ADDR, 1'b1, 1'b0, 1'b0);
                repeat (mw) cyc(V_MEMS, 1'b1, 1'b0, 1'b0);
                cyc(V_MEMS, 1'b1, 1'b1, 1'b1);
            end
            OP_BRANCH: cyc(z ? V_BR1 : V_BR0, 1'b1, 1'b1, 1'b1);
            OP_JAL:    cyc(V_JMP, 1'b1, 1'b1, 1'b1);
            default:   cyc(V_TRAP, 1'b1, 1'b1, 1'b0);
        endcase
    endtask

    task automatic test_reset();
        cur_sel = 1'b0;
        do_reset();
    endtask

    task automatic test_rtype();
        run_instr(OP_R, 0, 0, 1'b0);
        opcode = OP_R;
        cyc(V_F0, 1'b0, 1'b1, 1'b0);   // instret must now read 1
    endtask

    task automatic test_load_wait();
        cur_sel = 1'b0;
        do_reset();
        run_instr(OP_LOAD, 0, 3, 1'b0);
        cyc(V_F0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_branch();
        run_instr(OP_BRANCH, 0, 0, 1'b1);
        run_instr(OP_BRANCH, 0, 0, 1'b0);
        cyc(V_F0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_instr(OP_I, 2, 0, 1'b0);
        run_instr(OP_LUI, 0, 0, 1'b1);
        run_instr(OP_JAL, 1, 0, 1'b0);
        run_instr(OP_STORE, 0, 2, 1'b0);
        run_instr(OP_LOAD, 0, 0, 1'b1);
        run_instr(OP_STORE, 0, 0, 1'b0);
        run_instr(OP_R, 1, 0, 1'b1);
        cyc(V_F0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
        cur_sel = 1'b0;
        do_reset();
        run_instr(OP_R, 0, 0, 1'b0);
        run_instr(7'b1111111, 0, 0, 1'b0);
        repeat (3) cyc(V_TRAP, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_trap_nojump();
        cur_sel = 1'b1;
        do_reset();
        run_instr(OP_R, 0, 0, 1'b0);
        opcode = OP_JAL;
        cyc(V_F1, 1'b1, 1'b1, 1'b0);
        cyc(V_DEC, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc(V_TRAP, 1'b1, i[0], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_illegal_instr !== 1'b0) begin
            errors++;
            $display("FAIL async_clear_illegal: got %b expected 0", b_illegal_instr);
        end
        checks++;
        if (b_instret !== 4'd0) begin
            errors++;
            $display("FAIL async_clear_instret: got %0d expected 0", b_instret);
        end
    endtask

    task automatic test_wrap();
        cur_sel = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) run_instr(OP_STORE, i % 2, i % 3, 1'b0);
        opcode = OP_STORE;
        cyc(V_F1, 1'b1, 1'b1, 1'b0);    // instret wrapped to 0
        cyc(V_DEC, 1'b1, 1'b1, 1'b0);
        cyc(V_ADDR, 1'b1, 1'b0, 1'b0);
        #2;
        checks++;
        if (b_mem_write !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_write_before_reset: got %b expected 1", b_mem_write);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_mem_write !== 1'b0) begin
            errors++;
            $display("FAIL mid_mem_write_async_drop: got %b expected 0", b_mem_write);
        end
        checks++;
        if (b_state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL mid_mem_state_async: got %0d expected 0", b_state_dbg);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_trap_nojump();
        test_wrap();
        cur_sel = 1'b0;
        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle control unit for the RISC-V core, the next generation of the single-cycle main controller. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the shared-datapath mux selects and write enables. It handshakes with a variable-latency memory and counts retired instructions. It sits between the instruction register's opcode field and the multi-cycle datapath (PC, IR, MDR, ALUOut, register file).

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `SUPPORT_JUMP`, 1: 1 = JAL (1101111) and LUI (0110111) are decoded; 0 = they trap as illegal.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR[6:0]; valid from DECODE onward.
- `instr_valid` in 1: fetched instruction word present on the memory bus.
- `mem_ready` in 1: data memory access complete this cycle.
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: load PC.
- `pc_src` out 2: 00 ALU result, 01 ALUOut.
- `ir_write` out 1: load IR.
- `i_or_d` out 1: memory address select; 0 PC, 1 ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `alu_src_a` out 2: 00 PC, 01 rs1, 10 zero, 11 old PC.
- `alu_src_b` out 2: 00 rs2, 01 constant 4, 10 immediate.
- `alu_op` out 2: 00 add, 01 subtract/compare, 10 funct decode.
- `mem_to_reg` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `reg_write` out 1: register file write enable.
- `illegal_instr` out 1: sticky trap flag.
- `instret` out CNT_W: retired-instruction count.
- `state_dbg` out 4: current state encoding.

## Operation
- States are RST, FETCH, DECODE, EXEC, ADDR, MEM, WB, BRANCH, JUMP and TRAP.
- Outputs are a decode of the state register. Exceptions: `pc_write`/`ir_write` are gated by `instr_valid` in FETCH, and `pc_write` is gated by `zero` in BRANCH. Unlisted outputs are 0.
- RST: all outputs 0. Unconditional transition to FETCH.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - On `instr_valid`: `ir_write`=1, `pc_write`=1, go to DECODE.
  - Otherwise hold.
- DECODE: `alu_src_a`=11, `alu_src_b`=10, `alu_op`=00, so ALUOut = branch/jump target. The opcode class is registered here. Transitions by opcode:
  - 0110011 or 0010011 → EXEC.
  - 0000011 or 0100011 → ADDR.
  - 1100011 → BRANCH.
  - 1101111 → JUMP, when `SUPPORT_JUMP`.
  - 0110111 → EXEC, when `SUPPORT_JUMP`.
  - Anything else → TRAP.
- EXEC: `alu_op`=10.
  - R-type: `alu_src_a`=01, `alu_src_b`=00.
  - I-ALU: `alu_src_a`=01, `alu_src_b`=10.
  - LUI: `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00.
  - Then → WB.
- ADDR: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00. Then → MEM.
- MEM: `i_or_d`=1. Load asserts `mem_read`; store asserts `mem_write`. The request is held until `mem_ready`=1 is sampled.
  - Load then → WB.
  - Store then → FETCH and retires.
- WB: `reg_write`=1, `mem_to_reg`=01 for load, 00 otherwise. Then → FETCH and retires.
- BRANCH: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `pc_write`=`zero`. Then → FETCH and retires. funct3 is ignored; behaviour is BEQ only.
- JUMP: `pc_src`=01, `pc_write`=1, `reg_write`=1, `mem_to_reg`=10. Then → FETCH and retires.
- TRAP: `illegal_instr`=1. Absorbing; only `rst_n` exits. `instret` is not incremented.
- Retirement: `instret` increments by 1 on each retiring transition and wraps modulo 2^CNT_W.

## Timing
- `rst_n` low: state forced to RST and `instret`=0 immediately, regardless of current state (including mid-MEM or TRAP). All outputs are 0 while reset is low and in the first cycle after release.
- Minimum cycles per instruction, with zero wait states:
  - branch and JAL: 3.
  - R-type, I-ALU, LUI and store: 4.
  - load: 5.
- Each wait cycle (`instr_valid` or `mem_ready` low) adds exactly 1 cycle.
- `mem_ready` high on the first MEM cycle completes the access in 1 cycle.
- `instret` updates on the clock edge that leaves the retiring state; it is visible the next cycle.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - opcode constants;
  - the state enum with 4-bit encodings;
  - the `alu_src_a`/`alu_src_b`/`mem_to_reg`/`pc_src`/`alu_op` encodings;
  - the opcode-class enum.
- One sub-module, `riscv_opcode_classifier`: combinational opcode → class mapping, parametrised by `SUPPORT_JUMP`.

## Test plan
- Reset, then R-type (0110011) with `instr_valid` tied 1 → state sequence FETCH, DECODE, EXEC, WB, FETCH. `reg_write`=1 only in WB. `instret`=1.
- Load (0000011) with `mem_ready` low for 3 MEM cycles → `mem_read`=1, `i_or_d`=1 held for 4 cycles. WB with `mem_to_reg`=01. Total 8 cycles.
- Two BRANCH cases, each checking `pc_src`=01:
  - Branch with `zero`=1 → `pc_write`=1 in BRANCH.
  - Branch with `zero`=0 → `pc_write`=0 in BRANCH.
- `SUPPORT_JUMP`=0, opcode 1101111 → TRAP. `illegal_instr` stays 1 for 10+ cycles and `instret` is unchanged. Asserting `rst_n`=0 clears both asynchronously.
- Preload `instret`=2^CNT_W−1 (CNT_W=4, 15 stores) → the 16th store wraps `instret` to 0. Reset pulse asserted mid-MEM → `mem_write` drops to 0 without waiting for a clock edge.
